zet_prefetch_queue: RTL

Byte-wide instruction prefetch queue feeding the Zet fetch/decode front end. Fetches aligned 16-bit words from memory at CS:IP through a request/ack handshake and buffers them as bytes. Presents the two oldest bytes to the fetch stage, which pops 0-2 bytes per cycle to assemble opcode, modrm, offset and immediate. Supports flushing on control transfer: jumps, calls, interrupts and loads of CS.

---
 rtl/zet_prefetch_queue_pkg.sv | 22 ++
 rtl/zet_prefetch_queue_if.sv | 16 +
 rtl/zet_prefetch_buf.sv | 68 ++++++
 rtl/zet_prefetch_queue.sv | 121 ++++++++++++
 4 files changed

// File: rtl/zet_prefetch_queue_pkg.sv
// rtl/zet_prefetch_queue_pkg.sv - shared constants, FSM encoding and address helper for the prefetch queue
// Contents: reset CS:IP vector, physical address width, request FSM states,
//           word_addr() mapping CS:IP to the 19-bit word address.
package zet_prefetch_queue_pkg;

  localparam logic [15:0] ZET_RESET_CS = 16'hF000;
  localparam logic [15:0] ZET_RESET_IP = 16'hFFF0;
  localparam int          PHYS_W       = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request on the bus
    S_REQ  = 2'd1,  // request outstanding, data will be queued
    S_DROP = 2'd2   // request outstanding, data will be discarded
  } req_state_e;

  // phys = {cs,4'b0} + ip (mod 2^20); bit 0 of phys is always ip[0] since cs
  // contributes nothing there, so the word address is {cs,3'b0} + ip[15:1].
  function automatic logic [PHYS_W-2:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 3'b000} + {4'b0000, ip[15:1]};
  endfunction

endpackage

// File: rtl/zet_prefetch_queue_if.sv
// rtl/zet_prefetch_queue_if.sv - memory read request/ack bus between the prefetch queue and memory
// Signals: mem_req (request, held until ack), mem_adr (word address),
//          mem_ack (read complete), mem_dat (read data, low byte at even address).
// Modports: master = prefetch queue, slave = memory.
interface zet_prefetch_queue_if;
  import zet_prefetch_queue_pkg::*;

  logic              mem_req;
  logic [PHYS_W-2:0] mem_adr;
  logic              mem_ack;
  logic [15:0]       mem_dat;

  modport master (output mem_req, output mem_adr, input mem_ack, input mem_dat);
  modport slave  (input mem_req, input mem_adr, output mem_ack, output mem_dat);

endinterface

// File: rtl/zet_prefetch_buf.sv
// rtl/zet_prefetch_buf.sv - DEPTH-byte circular store with 2-byte write and 2-byte read ports
// Ports: clk, rst (async active-low), clr (empty the store),
//        push_n/push_dat (0-2 bytes in, first byte in [7:0]),
//        pop (requested bytes out), pop_eff (min(pop, cnt)),
//        cnt/cnt_nxt (current/next byte count), rd_dat (head byte in [7:0]).
module zet_prefetch_buf #(
  parameter int DEPTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       push_n,
  input  logic [15:0]      push_dat,
  input  logic [1:0]       pop,
  output logic [1:0]       pop_eff,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [15:0]      rd_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr1, wr_ptr1;
  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;

  // Pointer advance mod DEPTH; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign rd_ptr1 = ptr_add(rd_ptr, 2'd1);
  assign wr_ptr1 = ptr_add(wr_ptr, 2'd1);

  assign pop_eff    = (CNT_W'(pop) > cnt) ? cnt[1:0] : pop;
  assign cnt_nxt    = clr ? '0 : cnt + CNT_W'(push_n) - CNT_W'(pop_eff);
  assign rd_ptr_nxt = clr ? '0 : ptr_add(rd_ptr, pop_eff);
  assign wr_ptr_nxt = clr ? '0 : ptr_add(wr_ptr, push_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Storage needs no reset: lanes beyond cnt are masked on the read side.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (push_n != 2'd0) mem[wr_ptr]  <= push_dat[7:0];
      if (push_n == 2'd2) mem[wr_ptr1] <= push_dat[15:8];
    end
  end

  assign rd_dat[7:0]  = (cnt != '0)          ? mem[rd_ptr]  : 8'h00;
  assign rd_dat[15:8] = (cnt >= CNT_W'(2))   ? mem[rd_ptr1] : 8'h00;

endmodule

// File: rtl/zet_prefetch_queue.sv
// rtl/zet_prefetch_queue.sv - byte-wide instruction prefetch queue for the Zet fetch front end
// Ports: clk, rst (async active-low), flush/flush_cs/flush_ip (restart fetch),
//        mem (zet_prefetch_queue_if.master: mem_req/mem_adr/mem_ack/mem_dat),
//        pop (bytes consumed), q_cnt (bytes valid), q_dat (head byte in [7:0]),
//        cur_ip (IP of head byte).
// Option: ZET_PREFETCH_STATS_EN adds stall_cnt and flush_cnt (saturating).
module zet_prefetch_queue
  import zet_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [15:0]                 flush_cs,
  input  logic [15:0]                 flush_ip,
  zet_prefetch_queue_if.master        mem,
  input  logic [1:0]                  pop,
  output logic [CNT_W-1:0]            q_cnt,
  output logic [15:0]                 q_dat,
  output logic [15:0]                 cur_ip
`ifdef ZET_PREFETCH_STATS_EN
  ,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 flush_cnt
`endif
);

  req_state_e        state, state_nxt;
  logic [15:0]       cs, fetch_ip;
  logic [15:0]       cs_nxt, fetch_ip_nxt;
  logic [PHYS_W-2:0] adr_q;
  logic              push;
  logic [1:0]        push_n;
  logic [15:0]       push_dat;
  logic [1:0]        pop_eff;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              space_ok;
  logic              issue;

  zet_prefetch_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_n   (push_n),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_eff  (pop_eff),
    .cnt      (q_cnt),
    .cnt_nxt  (cnt_nxt),
    .rd_dat   (q_dat)
  );

  // Decided on post-edge occupancy so a request can go out the cycle right
  // after an ack or a freeing pop, while mem_req itself stays registered.
  assign space_ok = (cnt_nxt <= CNT_W'(DEPTH - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = space_ok ? S_REQ : S_IDLE;
      S_REQ: begin
        if (mem.mem_ack) state_nxt = space_ok ? S_REQ : S_IDLE;
        else if (flush)  state_nxt = S_DROP;  // bus cannot abort; discard later
      end
      S_DROP: begin
        if (mem.mem_ack) state_nxt = space_ok ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = (state != S_IDLE);
    // Data returned in a flush cycle belongs to the old stream.
    push        = (state == S_REQ) && mem.mem_ack && !flush;
    push_n      = push ? (fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
    push_dat    = fetch_ip[0] ? {8'h00, mem.mem_dat[15:8]} : mem.mem_dat;
  end

  assign mem.mem_adr = adr_q;

  // A fresh address is latched only when a new request starts; an outstanding
  // request keeps its address even if a flush moves CS:IP.
  assign issue        = (state_nxt == S_REQ) && ((state == S_IDLE) || mem.mem_ack);
  assign cs_nxt       = flush ? flush_cs : cs;
  assign fetch_ip_nxt = flush ? flush_ip : fetch_ip + {14'd0, push_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs       <= ZET_RESET_CS;
      fetch_ip <= ZET_RESET_IP;
      cur_ip   <= ZET_RESET_IP;
      adr_q    <= '0;
    end else begin
      cs       <= cs_nxt;
      fetch_ip <= fetch_ip_nxt;
      cur_ip   <= flush ? flush_ip : cur_ip + {14'd0, pop_eff};
      if (issue) adr_q <= word_addr(cs_nxt, fetch_ip_nxt);
    end
  end

`ifdef ZET_PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (q_cnt == '0 && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)                  flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
